// File: rtl/pipeline_hazard_unit.sv
// Hazard controller for the 5-stage MIPS pipeline: forwarding selects, load-use and HI/LO stalls, redirect flushes, mult/div busy timer.
// Optional stall/flush performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_unit #(
  parameter int MULDIV_LATENCY = 8,
  parameter int CNT_W          = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [4:0]       RS_D,
  input  logic [4:0]       RT_D,
  input  logic [4:0]       RS_E,
  input  logic [4:0]       RT_E,
  input  logic [4:0]       WRITEREG_E,
  input  logic [4:0]       WRITEREG_M,
  input  logic [4:0]       WRITEREG_WB,
  input  logic             REGWRITE_E,
  input  logic             REGWRITE_M,
  input  logic             REGWRITE_WB,
  input  logic             MEMTOREG_E,
  input  logic             PCSRC_M,
  input  logic             MULDIV_START_E,
  input  logic             USES_HILO_D,
  output logic [1:0]       FORWARDA_E,
  output logic [1:0]       FORWARDB_E,
  output logic             STALL_F,
  output logic             STALL_D,
  output logic             FLUSH_D,
  output logic             FLUSH_E,
  output logic             FLUSH_M,
  output logic             MULDIV_BUSY
`ifdef HAZARD_PERF_CNT_EN
  ,
  input  logic             PERF_CLR,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
`endif
);

  localparam logic [7:0] MD_LAT = 8'(MULDIV_LATENCY);

  logic [7:0] md_cnt;
  logic       lw_stall;
  logic       md_stall;
  logic       any_stall;

  // M result is younger than WB, so it takes priority when both match.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (REGWRITE_M && (WRITEREG_M != 5'd0) && (WRITEREG_M == src))
      return 2'b10;
    else if (REGWRITE_WB && (WRITEREG_WB != 5'd0) && (WRITEREG_WB == src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    FORWARDA_E = fwd_sel(RS_E);
    FORWARDB_E = fwd_sel(RT_E);
  end

  assign lw_stall  = MEMTOREG_E && REGWRITE_E && (WRITEREG_E != 5'd0) &&
                     ((WRITEREG_E == RS_D) || (WRITEREG_E == RT_D));
  assign md_stall  = MULDIV_BUSY && USES_HILO_D;
  assign any_stall = lw_stall || md_stall;

  // A redirect overrides any stall so the new PC is accepted.
  assign STALL_F = any_stall && !PCSRC_M;
  assign STALL_D = any_stall && !PCSRC_M;
  assign FLUSH_E = any_stall || PCSRC_M;
  assign FLUSH_D = PCSRC_M;
  assign FLUSH_M = PCSRC_M;

  // A mult/div in E during a redirect is wrong-path and must not start the timer.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      md_cnt <= 8'd0;
    else if (MULDIV_START_E && !PCSRC_M)
      md_cnt <= MD_LAT;
    else if (md_cnt != 8'd0)
      md_cnt <= md_cnt - 8'd1;
  end

  assign MULDIV_BUSY = (md_cnt != 8'd0);

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      STALL_CNT <= '0;
      FLUSH_CNT <= '0;
    end else if (PERF_CLR) begin
      STALL_CNT <= '0;
      FLUSH_CNT <= '0;
    end else begin
      if (STALL_D && (STALL_CNT != '1))
        STALL_CNT <= STALL_CNT + 1'b1;
      if (PCSRC_M && (FLUSH_CNT != '1))
        FLUSH_CNT <= FLUSH_CNT + 1'b1;
    end
  end
`endif

endmodule
